ulpi_reg_writer: RTL and testbench

ULPI_REG_WRITER -- requirements
Module: ulpi_reg_writer

---
 rtl/ulpi_reg_writer.sv | 152 +++++++++++++++
 tb/tb_ulpi_reg_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_writer.sv
// rtl/ulpi_reg_writer.sv - ULPI link-side PHY register writer with standalone STP and nxt timeout
module ulpi_reg_writer #(
    parameter int NXT_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp,
    input  logic       phy_write_i,
    input  logic       phy_stop_i,
    input  logic [7:0] phy_addr_i,
    input  logic [7:0] phy_data_i,
    output logic       phy_busy_o,
    output logic       phy_done_o,
    output logic       phy_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_STP,
        S_STOP,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [8:0] WAIT_LAST = 9'(NXT_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       dir_q;
    logic       rst_stp;
    logic       err_q;
    logic       err_nxt;
    logic [7:0] addr_q;
    logic [7:0] addr_nxt;
    logic [7:0] data_q;
    logic [7:0] data_nxt;
    logic [8:0] wait_cnt;
    logic [8:0] wait_nxt;
    logic [7:0] bus_data;
    logic       bus_stp;
    logic       owned;
    logic       timeout;

    // The turnaround cycle after the PHY releases the bus is not ours yet.
    assign owned   = !ulpi_dir && !dir_q;
    assign timeout = (wait_cnt >= WAIT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            dir_q    <= 1'b1;
            rst_stp  <= 1'b1;
            err_q    <= 1'b0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            wait_cnt <= 9'd0;
        end else begin
            state    <= state_nxt;
            dir_q    <= ulpi_dir;
            rst_stp  <= 1'b0;
            err_q    <= err_nxt;
            addr_q   <= addr_nxt;
            data_q   <= data_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        err_nxt    = err_q;
        addr_nxt   = addr_q;
        data_nxt   = data_q;
        wait_nxt   = wait_cnt;
        bus_data   = 8'h00;
        bus_stp    = 1'b0;
        phy_busy_o = 1'b1;
        phy_done_o = 1'b0;
        phy_err_o  = 1'b0;
        case (state)
            S_IDLE: begin
                phy_busy_o = 1'b0;
                if (owned) begin
                    if (phy_stop_i) begin
                        state_nxt = S_STOP;
                        err_nxt   = 1'b0;
                    end else if (phy_write_i) begin
                        state_nxt = S_CMD;
                        err_nxt   = 1'b0;
                        addr_nxt  = phy_addr_i;
                        data_nxt  = phy_data_i;
                        wait_nxt  = 9'd0;
                    end
                end
            end
            S_CMD: begin
                bus_data = addr_q;
                if (ulpi_dir) begin
                    state_nxt = S_ABORT;
                end else if (ulpi_nxt) begin
                    state_nxt = S_DATA;
                    wait_nxt  = 9'd0;
                end else if (timeout) begin
                    state_nxt = S_STP;
                    err_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 9'd1;
                end
            end
            S_DATA: begin
                bus_data = data_q;
                if (ulpi_dir) begin
                    state_nxt = S_ABORT;
                end else if (ulpi_nxt) begin
                    state_nxt = S_STP;
                end else if (timeout) begin
                    state_nxt = S_STP;
                    err_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 9'd1;
                end
            end
            S_STP, S_STOP: begin
                bus_stp   = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                phy_done_o = 1'b1;
                phy_err_o  = err_q;
                state_nxt  = S_IDLE;
            end
            S_ABORT: begin
                // Retry from the TX CMD byte once the bus is ours again.
                if (owned) begin
                    state_nxt = S_CMD;
                    wait_nxt  = 9'd0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ulpi_data_oe = owned;
    assign ulpi_data_o  = owned ? bus_data : 8'h00;
    assign ulpi_stp     = rst_stp | (owned & bus_stp);

endmodule

// File: tb/tb_ulpi_reg_writer.sv
// tb/tb_ulpi_reg_writer.sv - randomized bench for ulpi_reg_writer against a per-transaction expected trace
module tb_ulpi_reg_writer;

    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ulpi_dir = 1'b0;
    logic       ulpi_nxt = 1'b0;
    logic [7:0] ulpi_data_o;
    logic       ulpi_data_oe;
    logic       ulpi_stp;
    logic       phy_write_i = 1'b0;
    logic       phy_stop_i = 1'b0;
    logic [7:0] phy_addr_i = 8'h00;
    logic [7:0] phy_data_i = 8'h00;
    logic       phy_busy_o;
    logic       phy_done_o;
    logic       phy_err_o;

    ulpi_reg_writer #(.NXT_TIMEOUT(T)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ulpi_dir    (ulpi_dir),
        .ulpi_nxt    (ulpi_nxt),
        .ulpi_data_o (ulpi_data_o),
        .ulpi_data_oe(ulpi_data_oe),
        .ulpi_stp    (ulpi_stp),
        .phy_write_i (phy_write_i),
        .phy_stop_i  (phy_stop_i),
        .phy_addr_i  (phy_addr_i),
        .phy_data_i  (phy_data_i),
        .phy_busy_o  (phy_busy_o),
        .phy_done_o  (phy_done_o),
        .phy_err_o   (phy_err_o)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Vector layout: {data[7:0], oe, stp, busy, done, err}
    task automatic check(input string tag, input logic [12:0] act, input logic [12:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got data=%h oe/stp/busy/done/err=%b, expected data=%h oe/stp/busy/done/err=%b",
                     tag, act[12:5], act[4:0], exp[12:5], exp[4:0]);
        end
    endtask

    typedef struct packed {
        logic        dir;
        logic        nxt;
        logic        wr;
        logic        sr;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [12:0] exp;
    } step_t;

    step_t steps[$];
    string tags[$];

    function automatic logic [12:0] ev(input logic [7:0] d, input logic oe, input logic stp,
                                       input logic busy, input logic done, input logic err);
        return {d, oe, stp, busy, done, err};
    endfunction

    function automatic logic [12:0] observed();
        return {ulpi_data_o, ulpi_data_oe, ulpi_stp, phy_busy_o, phy_done_o, phy_err_o};
    endfunction

    task automatic push(input string tag, input logic dir, input logic nxt, input logic wr,
                        input logic sr, input logic [7:0] a, input logic [7:0] d, input logic [12:0] exp);
        steps.push_back({dir, nxt, wr, sr, a, d, exp});
        tags.push_back(tag);
    endtask

    // tmo: 0 none, 1 nxt never comes in CMD, 2 nxt never comes in DATA
    task automatic gen_write(input logic [7:0] a, input logic [7:0] d, input int cw, input int dw,
                             input int ab_len, input int ab_at, input int tmo);
        logic err;
        err = (tmo != 0);
        push("idle", 0, 0, 0, 0, a, d, ev(8'h00, 1, 0, 0, 0, 0));
        push("accept", 0, 0, 1, 0, a, d, ev(8'h00, 1, 0, 0, 0, 0));
        if (tmo == 1) begin
            for (int i = 0; i < T; i++) push("cmd_tmo", 0, 0, 0, 0, 8'h00, 8'h00, ev(a, 1, 0, 1, 0, 0));
        end else begin
            for (int i = 0; i < cw; i++) push("cmd_wait", 0, 0, 0, 0, 8'h00, 8'h00, ev(a, 1, 0, 1, 0, 0));
            push("cmd_nxt", 0, 1, 0, 0, 8'h00, 8'h00, ev(a, 1, 0, 1, 0, 0));
            if (tmo == 2) begin
                for (int i = 0; i < T; i++) push("data_tmo", 0, 0, 0, 0, 8'h00, 8'h00, ev(d, 1, 0, 1, 0, 0));
            end else begin
                if (ab_len > 0) begin
                    for (int i = 0; i < ab_at; i++)
                        push("data_wait", 0, 0, 0, 0, 8'h00, 8'h00, ev(d, 1, 0, 1, 0, 0));
                    for (int i = 0; i < ab_len; i++)
                        push("abort_dir", 1, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 0, 0, 1, 0, 0));
                    push("turnaround", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 0, 0, 1, 0, 0));
                    push("abort_owned", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 1, 0, 1, 0, 0));
                    push("retry_cmd", 0, 1, 0, 0, 8'h00, 8'h00, ev(a, 1, 0, 1, 0, 0));
                end
                for (int i = 0; i < dw; i++) push("data_wait", 0, 0, 0, 0, 8'h00, 8'h00, ev(d, 1, 0, 1, 0, 0));
                push("data_nxt", 0, 1, 0, 0, 8'h00, 8'h00, ev(d, 1, 0, 1, 0, 0));
            end
        end
        push("stp", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 1, 1, 1, 0, 0));
        push("done", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 1, 0, 1, 1, err));
        push("idle_after", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 1, 0, 0, 0, 0));
    endtask

    task automatic gen_stop(input logic with_write, input logic [7:0] a, input logic [7:0] d);
        push("idle", 0, 0, 0, 0, a, d, ev(8'h00, 1, 0, 0, 0, 0));
        push("stop_accept", 0, 0, with_write, 1, a, d, ev(8'h00, 1, 0, 0, 0, 0));
        push("stop_stp", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 1, 1, 1, 0, 0));
        push("stop_done", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 1, 0, 1, 1, 0));
        push("idle_after", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h00, 1, 0, 0, 0, 0));
    endtask

    task automatic run_steps();
        step_t s;
        string t;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            t = tags.pop_front();
            @(posedge clock);
            #1;
            ulpi_dir    = s.dir;
            ulpi_nxt    = s.nxt;
            phy_write_i = s.wr;
            phy_stop_i  = s.sr;
            if (s.wr || s.sr) begin
                phy_addr_i = s.a;
                phy_data_i = s.d;
            end else begin
                phy_addr_i = 8'($urandom);
                phy_data_i = 8'($urandom);
            end
            @(negedge clock);
            check(t, observed(), s.exp);
        end
    endtask

    initial begin
        int kind;
        reset_n     = 1'b0;
        phy_write_i = 1'b1;
        phy_addr_i  = 8'h84;
        phy_data_i  = 8'h54;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", observed(), ev(8'h00, 0, 1, 0, 0, 0));
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("first_edge_no_accept", observed(), ev(8'h00, 1, 0, 0, 0, 0));
        phy_write_i = 1'b0;

        gen_write(8'h84, 8'h54, 0, 0, 0, 0, 0);
        gen_write(8'h8A, 8'h00, 3, 0, 0, 0, 0);
        gen_write(8'h84, 8'h54, 0, 0, 5, 0, 0);
        gen_stop(1'b0, 8'h84, 8'h11);
        gen_stop(1'b1, 8'h84, 8'h22);
        gen_write(8'h84, 8'h33, 0, 0, 0, 0, 1);
        gen_write(8'h85, 8'h44, 1, 0, 0, 0, 2);
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: gen_write(8'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
                             int'($urandom_range(0, 5)), 0, 0, 0);
                1: gen_write(8'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
                             int'($urandom_range(0, 5)), int'($urandom_range(1, 5)),
                             int'($urandom_range(0, 2)), 0);
                2: gen_write(8'($urandom), 8'($urandom), 0, 0, 0, 0, 1);
                3: gen_write(8'($urandom), 8'($urandom), int'($urandom_range(0, 5)), 0, 0, 0, 2);
                default: gen_stop(1'($urandom), 8'($urandom), 8'($urandom));
            endcase
        end
        run_steps();

        gen_write(8'h84, 8'h54, 0, 0, 0, 0, 0);
        void'(steps.pop_back()); void'(tags.pop_back());
        void'(steps.pop_back()); void'(tags.pop_back());
        void'(steps.pop_back()); void'(tags.pop_back());
        void'(steps.pop_back()); void'(tags.pop_back());
        push("data_wait", 0, 0, 0, 0, 8'h00, 8'h00, ev(8'h54, 1, 0, 1, 0, 0));
        run_steps();
        #1 reset_n = 1'b0;
        #1 check("reset_mid_data", observed(), ev(8'h00, 0, 1, 0, 0, 0));
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("after_reset_idle", observed(), ev(8'h00, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("no_done_after_reset", observed(), ev(8'h00, 1, 0, 0, 0, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
